// File: rtl/regfile_pkg.sv
// Shared types and default MIPS32 widths for the multi-port register file.
package regfile_pkg;

   localparam int unsigned MIPS_ADDR_W   = 5;
   localparam int unsigned MIPS_DATA_W   = 32;
   localparam int unsigned MIPS_NUM_REGS = 32;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StClear = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: range check, hardwired-zero check and write bypass mux.
module regfile_rdport #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic [NUM_REGS*DATA_W-1:0] regs_i,
   input  logic                       busy_i,
   input  logic                       we0_i,
   input  logic [ADDR_W-1:0]          wa0_i,
   input  logic [DATA_W-1:0]          wd0_i,
   input  logic                       we1_i,
   input  logic [ADDR_W-1:0]          wa1_i,
   input  logic [DATA_W-1:0]          wd1_i,
   input  logic [ADDR_W-1:0]          rd_addr_i,
   output logic [DATA_W-1:0]          rd_data_o
);

   logic addr_ok;
   logic is_zero;

   assign addr_ok = ({1'b0, rd_addr_i} < (ADDR_W + 1)'(NUM_REGS));
   assign is_zero = (ZERO_REG != 0) && (rd_addr_i == '0);

   always_comb begin
      rd_data_o = '0;
      if (!busy_i && addr_ok && !is_zero) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (rd_addr_i == ADDR_W'(r)) rd_data_o = regs_i[r*DATA_W +: DATA_W];
         end
         // Write enables arrive already qualified, so port 1 overriding port 0 gives its priority.
         if (BYPASS != 0) begin
            if (we0_i && (wa0_i == rd_addr_i)) rd_data_o = wd0_i;
            if (we1_i && (wa1_i == rd_addr_i)) rd_data_o = wd1_i;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD read ports, hardware clear after reset.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W   = MIPS_ADDR_W,
   parameter int unsigned DATA_W   = MIPS_DATA_W,
   parameter int unsigned NUM_REGS = MIPS_NUM_REGS,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     Busy,
   input  logic                     RegWrite0,
   input  logic [ADDR_W-1:0]        WriteAddr0,
   input  logic [DATA_W-1:0]        WriteData0,
   input  logic                     RegWrite1,
   input  logic [ADDR_W-1:0]        WriteAddr1,
   input  logic [DATA_W-1:0]        WriteData1,
   input  logic [NUM_RD*ADDR_W-1:0] ReadAddr,
   output logic [NUM_RD*DATA_W-1:0] ReadData
);

   state_e                      state_q, state_d;
   logic [ADDR_W-1:0]           clr_ptr_q, clr_ptr_d;
   logic                        busy_q, busy_d;
   logic [DATA_W-1:0]           regs_q [NUM_REGS];
   logic [DATA_W-1:0]           regs_d [NUM_REGS];
   logic [NUM_REGS*DATA_W-1:0]  regs_flat;
   logic                        we0, we1;

   function automatic logic wr_addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign we0  = RegWrite0 && !reset && (state_q == StIdle) && wr_addr_ok(WriteAddr0);
   assign we1  = RegWrite1 && !reset && (state_q == StIdle) && wr_addr_ok(WriteAddr1);
   assign Busy = busy_q;

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      busy_d    = busy_q;
      regs_d    = regs_q;
      if (state_q == StClear) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (clr_ptr_q == ADDR_W'(r)) regs_d[r] = '0;
         end
         clr_ptr_d = clr_ptr_q + ADDR_W'(1);
         if (clr_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      end else begin
         // Port 1 is applied last so it wins an address conflict.
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (we0 && (WriteAddr0 == ADDR_W'(r))) regs_d[r] = WriteData0;
            if (we1 && (WriteAddr1 == ADDR_W'(r))) regs_d[r] = WriteData1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StClear;
         clr_ptr_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         busy_q    <= busy_d;
      end
      regs_q <= regs_d;
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_rdport #(
         .ADDR_W   (ADDR_W),
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rdport (
         .regs_i    (regs_flat),
         .busy_i    (busy_q),
         .we0_i     (we0),
         .wa0_i     (WriteAddr0),
         .wd0_i     (WriteData0),
         .we1_i     (we1),
         .wa1_i     (WriteAddr1),
         .wd1_i     (WriteData1),
         .rd_addr_i (ReadAddr[k*ADDR_W +: ADDR_W]),
         .rd_data_o (ReadData[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: two configurations of regfile_mp share one write stimulus stream.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        reset;
   logic        we0, we1;
   logic [4:0]  wa0, wa1;
   logic [31:0] wd0, wd1;
   logic [14:0] raddr_a;
   logic [95:0] rdata_a;
   logic        busy_a;
   logic [4:0]  raddr_b;
   logic [31:0] rdata_b;
   logic        busy_b;
   logic [31:0] pre [32];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   // A: 32 regs, 3 read ports, zero reg, bypass. B: 20 regs, 1 read port, no zero reg, no bypass.
   regfile_mp #(
      .NUM_RD (3), .ZERO_REG (1), .BYPASS (1)
   ) dut_a (
      .clk (clk), .reset (reset), .Busy (busy_a),
      .RegWrite0 (we0), .WriteAddr0 (wa0), .WriteData0 (wd0),
      .RegWrite1 (we1), .WriteAddr1 (wa1), .WriteData1 (wd1),
      .ReadAddr (raddr_a), .ReadData (rdata_a)
   );

   regfile_mp #(
      .NUM_REGS (20), .NUM_RD (1), .ZERO_REG (0), .BYPASS (0)
   ) dut_b (
      .clk (clk), .reset (reset), .Busy (busy_b),
      .RegWrite0 (we0), .WriteAddr0 (wa0), .WriteData0 (wd0),
      .RegWrite1 (we1), .WriteAddr1 (wa1), .WriteData1 (wd1),
      .ReadAddr (raddr_b), .ReadData (rdata_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic e1, input logic [4:0] a1, input logic [31:0] d1);
      we0 = e0; wa0 = a0; wd0 = d0;
      we1 = e1; wa1 = a1; wd1 = d1;
   endtask

   function automatic logic [31:0] rd_a(input int k);
      return rdata_a[k*32 +: 32];
   endfunction

   task automatic busy_run(input string tag);
      for (int i = 1; i <= 32; i++) begin
         tick();
         chk($sformatf("%s_busy_a_%0d", tag, i), 32'(busy_a), 32'(i < 32));
         chk($sformatf("%s_busy_b_%0d", tag, i), 32'(busy_b), 32'(i < 20));
         if (i == 14) wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
         if (i == 15) wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      end
   endtask

   task automatic sweep_zero(input string tag);
      for (int r = 0; r < 32; r++) begin
         raddr_a = {5'(r), 5'(r), 5'(r)};
         raddr_b = 5'(r);
         #1;
         chk($sformatf("%s_a_r%0d", tag, r), rd_a(2), 32'h0);
         chk($sformatf("%s_b_r%0d", tag, r), rdata_b, 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      raddr_a = '0;
      raddr_b = '0;
      repeat (3) tick();
      reset = 1'b0;
      busy_run("init");

      // Preload distinct random values, then check a couple of readbacks.
      for (int r = 1; r < 32; r++) begin
         pre[r] = $urandom;
         wr(1'b1, 5'(r), pre[r], 1'b0, 5'd0, 32'h0);
         tick();
      end
      wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      raddr_a = {5'd0, 5'd19, 5'd5};
      raddr_b = 5'd19;
      #1;
      chk("pre_a_r5", rd_a(0), pre[5]);
      chk("pre_a_r19", rd_a(1), pre[19]);
      chk("pre_b_r19", rdata_b, pre[19]);
      raddr_b = 5'd25;
      #1;
      chk("pre_b_r25_oor", rdata_b, 32'h0);

      // Reset held 3 cycles; reads are zero while busy, late write to reg 5 is dropped.
      reset = 1'b1;
      raddr_a = {5'd0, 5'd0, 5'd5};
      repeat (3) tick();
      chk("rst_busy_a", 32'(busy_a), 32'h1);
      chk("rst_read_zero_a", rd_a(0), 32'h0);
      reset = 1'b0;
      busy_run("clr");
      sweep_zero("clr_sweep");

      // Two writes in one cycle, read on three ports.
      wr(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd9, 32'hCAFEF00D);
      tick();
      wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      raddr_a = {5'd0, 5'd9, 5'd7};
      raddr_b = 5'd9;
      #1;
      chk("basic_p0", rd_a(0), 32'h12345678);
      chk("basic_p1", rd_a(1), 32'hCAFEF00D);
      chk("basic_p2", rd_a(2), 32'h0);
      chk("basic_b", rdata_b, 32'hCAFEF00D);

      // Write conflict: port 1 wins, including through bypass.
      wr(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
      raddr_a = {5'd3, 5'd3, 5'd3};
      raddr_b = 5'd3;
      #1;
      chk("conf_bypass_a", rd_a(0), 32'h2);
      chk("conf_nobypass_b", rdata_b, 32'h0);
      tick();
      wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("conf_after_a", rd_a(1), 32'h2);
      chk("conf_after_b", rdata_b, 32'h2);

      // Bypass on/off.
      wr(1'b1, 5'd4, 32'hAAAA, 1'b0, 5'd0, 32'h0);
      tick();
      wr(1'b1, 5'd4, 32'h5555, 1'b0, 5'd0, 32'h0);
      raddr_a = {5'd4, 5'd4, 5'd4};
      raddr_b = 5'd4;
      #1;
      chk("byp_a_same", rd_a(0), 32'h5555);
      chk("byp_b_old", rdata_b, 32'hAAAA);
      tick();
      wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("byp_a_after", rd_a(0), 32'h5555);
      chk("byp_b_after", rdata_b, 32'h5555);

      // Register 0: hardwired on A, ordinary on B.
      wr(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
      raddr_a = '0;
      raddr_b = 5'd0;
      #1;
      chk("zero_a_before", rd_a(0), 32'h0);
      chk("zero_b_before", rdata_b, 32'h0);
      tick();
      wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("zero_a_after", rd_a(2), 32'h0);
      chk("zero_b_after", rdata_b, 32'hFFFFFFFF);

      // Address 25 is legal on A, out of range on B.
      wr(1'b1, 5'd25, 32'h77, 1'b0, 5'd0, 32'h0);
      tick();
      wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      raddr_a = {5'd0, 5'd0, 5'd25};
      raddr_b = 5'd25;
      #1;
      chk("range_a", rd_a(0), 32'h77);
      chk("range_b", rdata_b, 32'h0);

      // Reset mid-clear restarts the sequence from pointer 0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      raddr_a = {5'd0, 5'd0, 5'd7};
      #1;
      chk("mid_read_zero_a", rd_a(0), 32'h0);
      busy_run("mid");
      sweep_zero("mid_sweep");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the MIPS32 datapath. It is the next generation of the single-write, dual-read register file. New capabilities:
- configurable number of read ports;
- two write ports with defined priority;
- optional hardwired $zero;
- optional write-to-read bypass;
- a hardware clear sequencer started by synchronous reset, replacing simulation-only initialisation.

It sits between decode (read addresses) and writeback (write ports).

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, number of registers (≤ 2**ADDR_W, ≥ 2)
NUM_RD, 2, number of read ports (≥ 1)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; starts the clear sequence
Busy  out  1  high while the clear sequence runs
RegWrite0  in  1  write enable, port 0
WriteAddr0  in  ADDR_W  write address, port 0
WriteData0  in  DATA_W  write data, port 0
RegWrite1  in  1  write enable, port 1
WriteAddr1  in  ADDR_W  write address, port 1
WriteData1  in  DATA_W  write data, port 1
ReadAddr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
ReadData  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. No initial blocks; contents are defined only by the clear sequence.
- FSM states: IDLE and CLEAR.
- Reset entry: any edge with reset=1 sets state to CLEAR, clr_ptr to 0 and Busy to 1. This applies from any state; reset during CLEAR restarts at pointer 0.
- Reset held: while reset=1, clr_ptr is held at 0.
- CLEAR step: each edge with reset=0 writes regs[clr_ptr] = 0 and increments clr_ptr.
- CLEAR exit: on the edge that clears NUM_REGS-1, state goes to IDLE and Busy goes to 0. Busy therefore falls exactly NUM_REGS edges after reset is released.
- Reset values: Busy=1; ReadData = all zeros while Busy. Power-up state before the first reset is undefined and is not checked.
- Writes while Busy: both write ports are ignored (dropped, not queued).
- Writes in IDLE: on the edge, if RegWrite0 is high, regs[WriteAddr0] is written with WriteData0; if RegWrite1 is high, regs[WriteAddr1] is written with WriteData1. Write latency is 1 edge.
- Write conflict: if both ports are enabled with equal addresses, port 1 wins. Port 0 data is discarded.
- Address range: a write address ≥ NUM_REGS is ignored. A read address ≥ NUM_REGS returns 0.
- ZERO_REG=1: writes to address 0 are dropped on both ports; every read of address 0 returns 0, including through bypass.
- Reads: combinational, no latency, from the register array.
- BYPASS=1: if a write port is enabled in IDLE with a legal, non-zero-protected address equal to ReadAddr[k], ReadData[k] returns that write data in the same cycle. If both ports match, port 1 data is returned. BYPASS=0 returns the old array value until the edge.
- Display: no $display or # delays inside the RTL.

Decomposition:
- Shared package regfile_pkg: FSM state encoding (IDLE, CLEAR) and the default widths MIPS_ADDR_W=5, MIPS_DATA_W=32, MIPS_NUM_REGS=32.
- Sub-module regfile_rdport: one instance per read port via generate. It contains the address-range check, the zero check and the bypass mux, and is parametrised by ADDR_W, DATA_W, ZERO_REG and BYPASS.
- The array, write logic and clear FSM stay in the top module.

Test Plan:
- Reset clear: preload random values, assert reset for 3 cycles, release -> Busy stays 1 for exactly 32 edges then 0; every register reads 0 afterwards; a write attempted during Busy (addr 5, 0xDEADBEEF) leaves reg 5 = 0.
- Basic write/read, NUM_RD=3: write reg 7=0x12345678 via port 0 and reg 9=0xCAFEF00D via port 1 in the same cycle -> the next cycle reads 7, 9, 0 on ports 0, 1, 2 and returns 0x12345678, 0xCAFEF00D, 0.
- Write conflict: both ports write reg 3 (port 0=0x1, port 1=0x2) -> reg 3 reads 0x2; with BYPASS=1, a same-cycle read of 3 shows 0x2.
- Bypass on/off: with reg 4=0xAAAA, write 0x5555 to reg 4 while reading 4 -> BYPASS=1 returns 0x5555 in the same cycle; BYPASS=0 returns 0xAAAA, then 0x5555 after the edge.
- Zero register: write 0xFFFFFFFF to reg 0 on both ports with reads of 0 -> ReadData=0 before and after; with ZERO_REG=0, reg 0 reads 0xFFFFFFFF after the edge.
- Reset mid-clear: release reset, wait 10 edges, assert reset for 1 cycle, release -> Busy high for 32 further edges (not 22); all registers read 0.
